// File: rtl/ddr_pixel_writer.sv
// Packs 24-bit RGB pixels five per word and writes each word to DDR at consecutive addresses.
// Define DDR_WR_TAG_EN to place {frame[4:0], valid pixel count[2:0]} in bits [127:120] of each word.
module ddr_pixel_writer #(
    parameter int unsigned DDR_DATA_WIDTH   = 128,
    parameter int unsigned NUMBER_OF_PIXELS = 196608,
    parameter int unsigned NUMBER_OF_FRAMES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [23:0]               pixel_in,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    input  logic                      ddr_wr_busy,
    output logic                      ddr_wr_en,
    output logic [DDR_DATA_WIDTH-1:0] ddr_wr_data,
    output logic [23:0]               ddr_addr,
    output logic                      frame_done,
    output logic                      end_of_write
);
    localparam int unsigned PIX_W  = 24;
    localparam int unsigned SLOTS  = 5;
    localparam int unsigned PCNT_W = $clog2(NUMBER_OF_PIXELS + 1);
    localparam int unsigned FCNT_W = 8;
    localparam logic [PCNT_W-1:0] LAST_PIX   = PCNT_W'(NUMBER_OF_PIXELS - 1);
    localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(NUMBER_OF_FRAMES - 1);

    typedef enum logic [1:0] {FILL, WRITE, DONE} state_t;

    state_t                    r_state;
    logic [2:0]                r_slot;
    logic [PCNT_W-1:0]         r_pix_cnt;
    logic [FCNT_W-1:0]         r_frame_cnt;
    logic                      r_frame_close;
    logic [DDR_DATA_WIDTH-1:0] r_data;
    logic [23:0]               r_addr;
    logic                      r_frame_done;
    logic                      r_eow;

    logic w_accept;
    logic w_strobe;
    logic w_word_full;
    logic w_frame_end;

    // Handshake and write strobe are combinational so a waiting word goes out the first non-busy cycle.
    assign pixel_ready  = (r_state == FILL) & ~reset;
    assign w_strobe     = (r_state == WRITE) & ~ddr_wr_busy & ~reset;
    assign w_accept     = pixel_valid & pixel_ready;
    assign w_word_full  = (r_slot == 3'(SLOTS - 1));
    assign w_frame_end  = (r_pix_cnt == LAST_PIX);

    assign ddr_wr_en    = w_strobe;
    assign ddr_wr_data  = r_data;
    assign ddr_addr     = r_addr;
    assign frame_done   = r_frame_done;
    assign end_of_write = r_eow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FILL;
            r_slot        <= '0;
            r_pix_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_frame_close <= 1'b0;
            r_data        <= '0;
            r_addr        <= '0;
            r_frame_done  <= 1'b0;
            r_eow         <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        for (int k = 0; k < int'(SLOTS); k++) begin
                            if (r_slot == 3'(k)) begin
                                r_data[k*PIX_W +: PIX_W] <= pixel_in;
                            end
                        end
`ifdef DDR_WR_TAG_EN
                        r_data[127:120] <= {r_frame_cnt[4:0], r_slot + 3'd1};
`endif
                        r_slot    <= r_slot + 3'd1;
                        r_pix_cnt <= r_pix_cnt + PCNT_W'(1);
                        // A frame's last pixel closes the word early so each frame starts on a fresh word.
                        if (w_word_full || w_frame_end) begin
                            r_state       <= WRITE;
                            r_frame_close <= w_frame_end;
                        end
                    end
                end
                WRITE: begin
                    if (w_strobe) begin
                        r_addr  <= r_addr + 24'd1;
                        r_data  <= '0;
                        r_slot  <= '0;
                        r_state <= FILL;
                        if (r_frame_close) begin
                            r_pix_cnt    <= '0;
                            r_frame_cnt  <= r_frame_cnt + FCNT_W'(1);
                            r_frame_done <= 1'b1;
                            if (r_frame_cnt == LAST_FRAME) begin
                                r_state <= DONE;
                                r_eow   <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_eow <= 1'b1;
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end
endmodule

// File: doc/ddr_pixel_writer.md
Name: ddr_pixel_writer

Overview:
- Packs a stream of 24-bit RGB pixels into 128-bit DDR words, 5 pixels per word, and issues one DDR write per word at consecutive word addresses.
- Sits between the video/image source and the DDR controller user interface, on the write side of the frame buffer.
- Signals completion with sticky end_of_write, which the DDR-to-BRAM pixel reading path waits on before it starts reading.
- Layout matches that reading path: pixel k of a word occupies bits [24k+23:24k]; each frame starts on a fresh word.

Parameters:
DDR_DATA_WIDTH  128  DDR word width; must be >= 120.
NUMBER_OF_PIXELS  196608  pixels per frame (512x384).
NUMBER_OF_FRAMES  1  frames to store before end_of_write; range 1..255.

Ports:
clk  in  1  system clock (DDR user clock); the only clock.
reset  in  1  synchronous, active-high reset.
pixel_in  in  24  RGB pixel, R in [23:16].
pixel_valid  in  1  pixel_in valid.
pixel_ready  out  1  block accepts pixel this cycle.
ddr_wr_busy  in  1  DDR controller cannot take a write.
ddr_wr_en  out  1  one-cycle write strobe.
ddr_wr_data  out  DDR_DATA_WIDTH  packed word.
ddr_addr  out  24  word address of the current write.
frame_done  out  1  one-cycle pulse after the last word of each frame is written.
end_of_write  out  1  sticky; all frames written.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: it acts only on a rising edge of clk while reset=1, and overrides all other updates.
- Reset values:
  - state=FILL; ddr_addr=0; slot counter=0; pixel-in-frame counter=0; frame counter=0.
  - ddr_wr_data=0; frame_done=0; end_of_write=0.
  - pixel_ready=0 and ddr_wr_en=0 while reset is high.
- Handshake: a pixel transfers on an edge where pixel_valid=1 and pixel_ready=1. pixel_ready=1 only in state FILL.
- FILL:
  - The accepted pixel is written into slot s, bits [24s+23:24s] of ddr_wr_data. s and the pixel-in-frame counter both increment.
  - Go to WRITE when s==4 or when the pixel is number NUMBER_OF_PIXELS-1 of the frame (partial word).
  - Unfilled slots and bits [127:120] stay 0.
- WRITE:
  - pixel_ready=0. ddr_wr_en = (state==WRITE) & ~ddr_wr_busy, combinational.
  - ddr_wr_data and ddr_addr are held stable for the whole time the block is in WRITE.
  - On the strobe edge: ddr_addr+1 (modulo 2^24), ddr_wr_data cleared, s=0, return to FILL.
  - If the word closed a frame: pixel-in-frame counter=0, frame counter+1, frame_done=1 on the next cycle.
  - If that frame was number NUMBER_OF_FRAMES-1: go to DONE instead of FILL.
- DONE:
  - end_of_write=1 until reset. pixel_ready=0, ddr_wr_en=0.
- Latency:
  - 5th pixel accepted at edge T -> ddr_wr_en high in cycle T+1 if ddr_wr_busy=0.
  - Best-case throughput is 5 pixels per 6 cycles.
- Addressing:
  - ddr_addr is contiguous across frames and is not reset per frame.
  - Words per frame = ceil(NUMBER_OF_PIXELS/5). For 196608 pixels: 39322 words, the last word holding 3 pixels.
- Busy: while ddr_wr_busy=1 in WRITE, the block waits indefinitely. No pixel is accepted and no output changes.
- Reset mid-operation: a partially filled word is discarded, no write is issued, and all counters return to 0.
- pixel_valid while pixel_ready=0 is ignored; the source must hold the pixel.

Optional Feature:
- Macro: DDR_WR_TAG_EN.
- Defined: bits [127:120] of each written word = {frame counter[4:0], number of valid pixels in the word [2:0]} (1..5).
- Undefined: bits [127:120] are always 0.
- All other behaviour is identical in both builds.

Test Plan:
- N=10, 1 frame, pixels 0x000001..0x00000A, busy=0 ->
  - write addr 0, data[119:0] = 0x000005_000004_000003_000002_000001;
  - write addr 1 with 0x00000A..0x000006;
  - frame_done pulse, then end_of_write=1; pixel_ready=0 afterwards.
- N=7 ->
  - word at addr 1 = pixels 6,7 in [47:0], bits [119:48]=0;
  - exactly 2 writes issued.
- ddr_wr_busy=1 for 20 cycles while in WRITE ->
  - ddr_wr_en=0 and pixel_ready=0 throughout, data/addr stable;
  - single strobe on the first cycle busy=0.
- NUMBER_OF_FRAMES=3, N=7 ->
  - addrs 0..5 written contiguously;
  - 3 frame_done pulses; end_of_write rises after the write to addr 5.
- Reset asserted after 3 pixels of a word ->
  - no write issued; after reset, first write goes to addr 0 with the new pixels only.
- DDR_WR_TAG_EN defined, N=7 ->
  - addr 0 bits [127:120]=0x05;
  - addr 1 bits [127:120]=0x02;
  - with a second frame, addr 2 bits [127:120]=0x0D.
